fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset and on start.
REQ-002 Parameter HALT_OPCODE, default 7'b1111111: instr[6:0] value that marks program exit.
REQ-003 Parameter DRAIN_CYCLES, default 4: cycles allowed after exit fetch for the pipeline to retire.
REQ-004 Parameter PC_LIMIT, default 32'd124: last legal fetch address (32-word window).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins fetch from RESET_PC.
REQ-008 stall  in  1  hazard-unit load-use stall.
REQ-009 branch_taken  in  1  EX-stage redirect request.
REQ-010 branch_target  in  32  redirect address, word aligned.
REQ-011 instr  in  32  word returned combinationally by instruction memory for pc.
REQ-012 pc  out  32  fetch address to instruction memory.
REQ-013 imem_stall  out  1  hold to instruction memory.
REQ-014 if_valid / if_instr / if_pc  out  1/32/32  registered IF/ID payload.
REQ-015 flush  out  1  squash of younger stages.
REQ-016 halted / overrun  out  1/1  program finished / ran past PC_LIMIT.

Function
REQ-017 States: IDLE, FETCH, DRAIN, HALT; encoded per shared package.
REQ-018 IDLE: pc=RESET_PC, if_valid=0, imem_stall=1; start -> FETCH next cycle.
REQ-019 FETCH, no stall, no branch: if_instr<=instr, if_pc<=pc, if_valid<=1, pc<=pc+4; one-cycle fetch latency.
REQ-020 stall=1: pc, if_valid, if_instr, if_pc held; imem_stall=1 same cycle.
REQ-021 branch_taken=1 (FETCH or DRAIN): flush=1 combinationally, pc<=branch_target, if_valid<=0 next cycle, state -> FETCH.
REQ-022 Priority: reset > branch_taken > stall > normal advance; branch with stall redirects.
REQ-023 Fetched instr[6:0]==HALT_OPCODE (not stalled): exit word issued with if_valid=1, pc frozen, state -> DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-024 DRAIN: if_valid=0, imem_stall=1, counter decrements per non-stall cycle; 0 -> HALT.
REQ-025 HALT: halted=1, imem_stall=1, if_valid=0; only reset or start leaves (start -> FETCH at RESET_PC, halted cleared).
REQ-026 FETCH with pc==PC_LIMIT advancing: that word issued, then overrun=1 and state -> HALT without drain; no wrap to 0.
REQ-027 branch_target > PC_LIMIT: overrun=1, state -> HALT next cycle, no fetch from target.
REQ-028 flush=0 in all cases except REQ-021.

Reset
REQ-029 reset asserted asynchronously forces state IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, overrun=0, drain counter 0; mid-fetch or mid-drain work is discarded.
REQ-030 First start accepted on the first clk edge after reset deasserts.

Configuration
REQ-031 FETCH_PERF_EN defined: outputs cyc_count[31:0] (cycles in FETCH/DRAIN), stall_count[31:0], flush_count[31:0], cleared on reset and start, saturating at all-ones, frozen in HALT.
REQ-032 FETCH_PERF_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-033 Shared package holds the state enum, HALT_OPCODE default, and instruction opcode field constants.
REQ-034 One sub-module natural: fetch_perf_cnt (saturating counter), instantiated three times under FETCH_PERF_EN.

Verification
REQ-035 reset, start; memory[0..2]=add,add,add; memory[3]=exit -> if_pc 0,4,8,12 consecutive, halted=1 exactly 4 cycles after exit issued.
REQ-036 stall high 2 cycles at pc=8 -> pc stays 8, if_pc stays 4, imem_stall=1 both cycles, fetch resumes at 8.
REQ-037 branch_taken with target 0x20 while stall=1 at pc=0x10 -> flush=1 that cycle, next pc=0x20, if_valid=0 one cycle.
REQ-038 branch_taken during DRAIN (exit at 0x0C, target 0x04) -> halt cancelled, fetch resumes at 0x04, halted stays 0.
REQ-039 no exit word, straight-line fetch -> word at 124 issued, overrun=1, halted=1, pc never 0 after 124.
REQ-040 reset asserted mid-DRAIN between clock edges -> state IDLE, outputs at reset values before next edge; with FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, the default exit opcode and the opcode field
// position used to recognise the exit word.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Opcode field of a 32-bit instruction word.
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;

  // Opcode values.
  localparam logic [6:0] HALT_OPCODE_DEF = 7'b1111111;
  localparam logic [6:0] OPC_OP          = 7'b0110011;

  // Width of the drain down-counter.
  localparam int DRAIN_CNT_W = 8;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping so a long run never reads as short.
module fetch_perf_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count events, clear on request, stop at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer feeding the IF/ID register.
// Handles start, load-use stall, EX redirect, program exit with a drain
// window, and a fetch-window limit. Build macro FETCH_PERF_EN adds
// cycle/stall/flush counters and their output ports.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, pc parked at RESET_PC
// FETCH | fetching one word per non-stall cycle
// DRAIN | exit word issued, waiting DRAIN_CYCLES for pipeline retire
// HALT  | program finished or overran; only start/reset leave
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [6:0]  HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] PC_LIMIT     = 32'd124
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic        o_imem_stall,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_flush,
  output logic        o_halted,
  output logic        o_overrun
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_cyc_count,
  output logic [31:0] o_stall_count,
  output logic [31:0] o_flush_count
`endif
);

  fetch_state_e           r_state, w_state_nxt;
  logic [31:0]            r_pc, w_pc_nxt;
  logic                   r_if_valid, w_if_valid_nxt;
  logic [31:0]            r_if_instr, w_if_instr_nxt;
  logic [31:0]            r_if_pc, w_if_pc_nxt;
  logic                   r_overrun, w_overrun_nxt;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt, w_drain_nxt;
  logic                   w_redirect;
  logic                   w_flush;

  assign w_redirect = i_branch_taken && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));

  // Next-state and next-payload decode; redirect outranks stall and advance.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_overrun_nxt  = r_overrun;
    w_drain_nxt    = r_drain_cnt;
    w_flush        = 1'b0;
    if (w_redirect) begin
      w_flush        = 1'b1;
      w_if_valid_nxt = 1'b0;
      w_drain_nxt    = '0;
      // A target outside the window is never fetched.
      if (i_branch_target > PC_LIMIT) begin
        w_overrun_nxt = 1'b1;
        w_state_nxt   = ST_HALT;
      end else begin
        w_pc_nxt    = i_branch_target;
        w_state_nxt = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pc_nxt       = RESET_PC;
          w_if_valid_nxt = 1'b0;
          if (i_start) w_state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (!i_stall) begin
            w_if_instr_nxt = i_instr;
            w_if_pc_nxt    = r_pc;
            w_if_valid_nxt = 1'b1;
            if (opcode_of(i_instr) == HALT_OPCODE) begin
              w_state_nxt = ST_DRAIN;
              w_drain_nxt = DRAIN_CNT_W'(DRAIN_CYCLES);
            end else if (r_pc >= PC_LIMIT) begin
              // Last legal word goes out; pc is frozen rather than wrapped.
              w_overrun_nxt = 1'b1;
              w_state_nxt   = ST_HALT;
            end else begin
              w_pc_nxt = r_pc + 32'd4;
            end
          end
        end
        ST_DRAIN: begin
          w_if_valid_nxt = 1'b0;
          if (!i_stall) begin
            // Terminal count at 1 so HALT lands DRAIN_CYCLES edges after exit.
            if (r_drain_cnt <= DRAIN_CNT_W'(1)) begin
              w_drain_nxt = '0;
              w_state_nxt = ST_HALT;
            end else begin
              w_drain_nxt = r_drain_cnt - 1'b1;
            end
          end
        end
        ST_HALT: begin
          w_if_valid_nxt = 1'b0;
          if (i_start) begin
            w_pc_nxt      = RESET_PC;
            w_overrun_nxt = 1'b0;
            w_state_nxt   = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_overrun   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_instr  <= w_if_instr_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_overrun   <= w_overrun_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  assign o_pc         = r_pc;
  assign o_imem_stall = (r_state == ST_FETCH) ? i_stall : 1'b1;
  assign o_if_valid   = r_if_valid;
  assign o_if_instr   = r_if_instr;
  assign o_if_pc      = r_if_pc;
  assign o_flush      = w_flush;
  assign o_halted     = (r_state == ST_HALT);
  assign o_overrun    = r_overrun;

`ifdef FETCH_PERF_EN
  logic w_perf_active;
  logic w_perf_clear;

  assign w_perf_active = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_perf_clear  = i_start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  fetch_perf_cnt #(.W(32)) u_cyc_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_perf_clear),
    .i_inc   (w_perf_active),
    .o_count (o_cyc_count)
  );

  fetch_perf_cnt #(.W(32)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_perf_clear),
    .i_inc   (w_perf_active && i_stall),
    .o_count (o_stall_count)
  );

  fetch_perf_cnt #(.W(32)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_perf_clear),
    .i_inc   (w_flush),
    .o_count (o_flush_count)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus hand sequences for fetch_ctrl.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] ADD_W  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP};
  localparam logic [31:0] EXIT_W = {25'd0, HALT_OPCODE_DEF};
  localparam int NV = 22;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_stall, i_branch_taken;
  logic [31:0] i_branch_target, i_instr;
  logic [31:0] o_pc, o_if_instr, o_if_pc;
  logic        o_imem_stall, o_if_valid, o_flush, o_halted, o_overrun;
`ifdef FETCH_PERF_EN
  logic [31:0] o_cyc_count, o_stall_count, o_flush_count;
`endif

  logic [31:0] mem [0:31];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        start, stall, br;
    logic [31:0] tgt;
    logic        e_flush, e_imem;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_if_pc;
    logic        e_halt, e_ov;
  } vec_t;

  vec_t tbl [NV];

  fetch_ctrl dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_instr         (i_instr),
    .o_pc            (o_pc),
    .o_imem_stall    (o_imem_stall),
    .o_if_valid      (o_if_valid),
    .o_if_instr      (o_if_instr),
    .o_if_pc         (o_if_pc),
    .o_flush         (o_flush),
    .o_halted        (o_halted),
    .o_overrun       (o_overrun)
`ifdef FETCH_PERF_EN
    ,
    .o_cyc_count     (o_cyc_count),
    .o_stall_count   (o_stall_count),
    .o_flush_count   (o_flush_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  assign i_instr = mem[o_pc[6:2]];

  function automatic vec_t mk(input logic s, st, b, input logic [31:0] t,
                              input logic ef, ei, input logic [31:0] ep,
                              input logic ev, input logic [31:0] eip,
                              input logic eh, eo);
    vec_t v;
    v.start = s; v.stall = st; v.br = b; v.tgt = t;
    v.e_flush = ef; v.e_imem = ei; v.e_pc = ep; v.e_valid = ev;
    v.e_if_pc = eip; v.e_halt = eh; v.e_ov = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, st, b, input logic [31:0] t);
    i_start = s; i_stall = st; i_branch_taken = b; i_branch_target = t;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_mem(input logic with_exit);
    for (int k = 0; k < 32; k++) mem[k] = ADD_W;
    if (with_exit) mem[3] = EXIT_W;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    drive(0, 0, 0, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //           st st br tgt     fl im  pc     v  if_pc  h  ov
    tbl[0]  = mk(1, 0, 0, 0,      0, 1, 32'd0,  0, 32'd0,  0, 0);
    tbl[1]  = mk(0, 0, 0, 0,      0, 0, 32'd4,  1, 32'd0,  0, 0);
    tbl[2]  = mk(0, 0, 0, 0,      0, 0, 32'd8,  1, 32'd4,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0,      0, 0, 32'd12, 1, 32'd8,  0, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0, 32'd12, 1, 32'd12, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 1, 0);
    tbl[10] = mk(1, 0, 0, 0,      0, 1, 32'd0,  0, 32'd12, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,      0, 0, 32'd4,  1, 32'd0,  0, 0);
    tbl[12] = mk(0, 0, 0, 0,      0, 0, 32'd8,  1, 32'd4,  0, 0);
    tbl[13] = mk(0, 1, 0, 0,      0, 1, 32'd8,  1, 32'd4,  0, 0);
    tbl[14] = mk(0, 1, 0, 0,      0, 1, 32'd8,  1, 32'd4,  0, 0);
    tbl[15] = mk(0, 0, 0, 0,      0, 0, 32'd12, 1, 32'd8,  0, 0);
    tbl[16] = mk(0, 0, 0, 0,      0, 0, 32'd12, 1, 32'd12, 0, 0);
    tbl[17] = mk(0, 1, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[18] = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,      0, 1, 32'd12, 0, 32'd12, 1, 0);

    // Reset state.
    set_mem(1'b1);
    i_reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst pc", o_pc, 32'd0);
    chk("rst if_valid", 32'(o_if_valid), 32'd0);
    chk("rst if_instr", o_if_instr, 32'd0);
    chk("rst if_pc", o_if_pc, 32'd0);
    chk("rst halted", 32'(o_halted), 32'd0);
    chk("rst overrun", 32'(o_overrun), 32'd0);
    chk("rst imem_stall", 32'(o_imem_stall), 32'd1);
    chk("rst flush", 32'(o_flush), 32'd0);
    i_reset = 1'b0;
    #1;

    // Exit program, restart, stall at pc=8, stall inside drain.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      chk($sformatf("v%0d flush", i), 32'(o_flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d imem_stall", i), 32'(o_imem_stall), 32'(tbl[i].e_imem));
      tick();
      chk($sformatf("v%0d pc", i), o_pc, tbl[i].e_pc);
      chk($sformatf("v%0d if_valid", i), 32'(o_if_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d if_pc", i), o_if_pc, tbl[i].e_if_pc);
      chk($sformatf("v%0d halted", i), 32'(o_halted), 32'(tbl[i].e_halt));
      chk($sformatf("v%0d overrun", i), 32'(o_overrun), 32'(tbl[i].e_ov));
    end
    chk("exit if_instr", o_if_instr, EXIT_W);

    // Branch together with stall at pc=0x10.
    set_mem(1'b0);
    do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    repeat (4) tick();
    chk("bs pc before", o_pc, 32'h10);
    drive(0, 1, 1, 32'h20);
    chk("bs flush", 32'(o_flush), 32'd1);
    tick();
    chk("bs pc", o_pc, 32'h20);
    chk("bs if_valid", 32'(o_if_valid), 32'd0);
    drive(0, 0, 0, 0);
    chk("bs flush after", 32'(o_flush), 32'd0);
    tick();
    chk("bs if_pc", o_if_pc, 32'h20);
    chk("bs if_valid after", 32'(o_if_valid), 32'd1);
    chk("bs pc after", o_pc, 32'h24);

    // Branch target beyond the window.
    drive(0, 0, 1, 32'h80);
    chk("far flush", 32'(o_flush), 32'd1);
    tick();
    chk("far halted", 32'(o_halted), 32'd1);
    chk("far overrun", 32'(o_overrun), 32'd1);
    chk("far if_valid", 32'(o_if_valid), 32'd0);
    chk("far pc", o_pc, 32'h24);

    // Branch during drain cancels the halt.
    set_mem(1'b1);
    do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    repeat (4) tick();
    chk("dr exit if_pc", o_if_pc, 32'h0C);
    tick();
    drive(0, 0, 1, 32'h04);
    chk("dr flush", 32'(o_flush), 32'd1);
    tick();
    chk("dr pc", o_pc, 32'h04);
    chk("dr if_valid", 32'(o_if_valid), 32'd0);
    drive(0, 0, 0, 0);
    tick();
    chk("dr resume if_pc", o_if_pc, 32'h04);
    chk("dr resume if_valid", 32'(o_if_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dr halted%0d", i), 32'(o_halted), 32'd0);
      tick();
    end

    // Straight-line run into the window limit.
    set_mem(1'b0);
    do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 31; i++) begin
      tick();
      chk($sformatf("lim pc%0d", i), o_pc, 32'(4 * (i + 1)));
    end
    chk("lim overrun early", 32'(o_overrun), 32'd0);
    tick();
    chk("lim if_pc", o_if_pc, 32'd124);
    chk("lim if_valid", 32'(o_if_valid), 32'd1);
    chk("lim overrun", 32'(o_overrun), 32'd1);
    chk("lim halted", 32'(o_halted), 32'd1);
    chk("lim pc", o_pc, 32'd124);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lim hold pc%0d", i), o_pc, 32'd124);
    end
    chk("lim if_valid after", 32'(o_if_valid), 32'd0);

    // Asynchronous reset between edges during drain, then first start.
    set_mem(1'b1);
    do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    repeat (5) tick();
    chk("ar pre pc", o_pc, 32'h0C);
    i_reset = 1'b1;
    #2;
    chk("ar pc", o_pc, 32'd0);
    chk("ar if_pc", o_if_pc, 32'd0);
    chk("ar if_instr", o_if_instr, 32'd0);
    chk("ar if_valid", 32'(o_if_valid), 32'd0);
    chk("ar halted", 32'(o_halted), 32'd0);
    chk("ar overrun", 32'(o_overrun), 32'd0);
    chk("ar imem_stall", 32'(o_imem_stall), 32'd1);
`ifdef FETCH_PERF_EN
    chk("ar cyc_count", o_cyc_count, 32'd0);
    chk("ar stall_count", o_stall_count, 32'd0);
    chk("ar flush_count", o_flush_count, 32'd0);
`endif
    i_reset = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    chk("ar start imem_stall", 32'(o_imem_stall), 32'd0);
    chk("ar start pc", o_pc, 32'd0);
    drive(0, 0, 0, 0);
    tick();
    chk("ar first if_valid", 32'(o_if_valid), 32'd1);
    chk("ar first if_pc", o_if_pc, 32'd0);
    chk("ar first pc", o_pc, 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
